// File: rtl/md_pkg.sv
// md_pkg: shared types for the force-writeback ring.
//   NUM_CELLS  - number of cells/nodes on the ring; valid dest_id is 0..NUM_CELLS-1
//   DEST_W     - width of dest_id; deliberately wide enough to carry out-of-range IDs
//   force_wb_t - force writeback request delivered to a cell's force cache
//   packet_t   - ring packet: destination ID plus force_wb_t payload
package md_pkg;
  localparam int NUM_CELLS = 12;
  localparam int DEST_W    = 4;

  typedef struct packed {
    logic [7:0]  atom_idx;
    logic [15:0] fx;
    logic [15:0] fy;
  } force_wb_t;

  typedef struct packed {
    logic [DEST_W-1:0] dest_id;
    force_wb_t         payload;
  } packet_t;
endpackage

// File: rtl/ring_packet_eject.sv
// ring_packet_eject: per-node receive end of the force-writeback ring.
// Packets addressed to HOME_CELL_ID are ejected into a first-word-fall-through
// FIFO and presented as force writeback requests; packets for other valid
// cells are forwarded downstream through a one-entry register; packets with
// an out-of-range destination are dropped and flagged.
//
// Parameters:
//   HOME_CELL_ID - this node's cell ID (0..NUM_CELLS-1)
//   FIFO_DEPTH   - eject FIFO entries, power of two, >= 2
//   CNT_WIDTH    - width of the saturating statistics counters
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   pkt_in/_valid/_ready          - upstream ring link (valid/ready)
//   pkt_fwd/_valid/_ready         - downstream ring link (valid/ready)
//   wb_out, wb_valid, wb_ready    - writeback request to local force cache
//   eject_cnt, fwd_cnt            - saturating ejected/forwarded packet counts
//   dest_err                      - sticky: a packet with dest_id >= NUM_CELLS arrived
module ring_packet_eject
  import md_pkg::*;
#(
  parameter int HOME_CELL_ID = 0,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  packet_t              pkt_in,
  input  logic                 pkt_in_valid,
  output logic                 pkt_in_ready,
  output packet_t              pkt_fwd,
  output logic                 pkt_fwd_valid,
  input  logic                 pkt_fwd_ready,
  output force_wb_t            wb_out,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [CNT_WIDTH-1:0] eject_cnt,
  output logic [CNT_WIDTH-1:0] fwd_cnt,
  output logic                 dest_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  force_wb_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;
  packet_t              r_fwd;
  logic                 r_fwd_valid;
  logic [CNT_WIDTH-1:0] r_eject_cnt;
  logic [CNT_WIDTH-1:0] r_fwd_cnt;
  logic                 r_dest_err;

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_accept;
  logic w_is_home;
  logic w_is_bad;
  logic w_push;
  logic w_pop;
  logic w_fwd_load;

  assign w_fifo_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_fifo_empty = (r_count == '0);

  // Ready depends only on local state, never on pkt_in content, so a stalled
  // downstream link blocks even packets addressed to this node.
  assign pkt_in_ready = !w_fifo_full && (!r_fwd_valid || pkt_fwd_ready);
  assign w_accept     = pkt_in_valid && pkt_in_ready;

  assign w_is_bad   = ({1'b0, pkt_in.dest_id} >= (DEST_W+1)'(NUM_CELLS));
  assign w_is_home  = (pkt_in.dest_id == DEST_W'(HOME_CELL_ID));
  assign w_push     = w_accept && w_is_home && !w_is_bad;
  assign w_fwd_load = w_accept && !w_is_home && !w_is_bad;
  assign w_pop      = !w_fifo_empty && wb_ready;

  // Empty FIFO presents zero rather than whatever stale entry the head points at.
  assign wb_out        = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
  assign wb_valid      = !w_fifo_empty;
  assign pkt_fwd       = r_fwd;
  assign pkt_fwd_valid = r_fwd_valid;
  assign eject_cnt     = r_eject_cnt;
  assign fwd_cnt       = r_fwd_cnt;
  assign dest_err      = r_dest_err;

  // NOTE: the storage array has no reset; validity is tracked by r_count, so
  // clearing it would only cost reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pkt_in.payload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Forward register: a load wins over a drain in the same cycle, giving
  // one packet per cycle with no bubble while downstream keeps up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd       <= '0;
      r_fwd_valid <= 1'b0;
    end else if (w_fwd_load) begin
      r_fwd       <= pkt_in;
      r_fwd_valid <= 1'b1;
    end else if (r_fwd_valid && pkt_fwd_ready) begin
      r_fwd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eject_cnt <= '0;
      r_fwd_cnt   <= '0;
      r_dest_err  <= 1'b0;
    end else begin
      if (w_push && (r_eject_cnt != '1))   r_eject_cnt <= r_eject_cnt + CNT_WIDTH'(1);
      if (w_fwd_load && (r_fwd_cnt != '1)) r_fwd_cnt   <= r_fwd_cnt + CNT_WIDTH'(1);
      if (w_accept && w_is_bad)            r_dest_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_packet_eject.sv
// Directed bench for ring_packet_eject: HOME_CELL_ID=5, FIFO_DEPTH=8,
// CNT_WIDTH=4 so that counter saturation is reachable in a short run.
module tb_ring_packet_eject;
  import md_pkg::*;

  localparam int HOME  = 5;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  packet_t       pkt_in;
  logic          pkt_in_valid;
  logic          pkt_in_ready;
  packet_t       pkt_fwd;
  logic          pkt_fwd_valid;
  logic          pkt_fwd_ready;
  force_wb_t     wb_out;
  logic          wb_valid;
  logic          wb_ready;
  logic [CW-1:0] eject_cnt;
  logic [CW-1:0] fwd_cnt;
  logic          dest_err;

  int total = 0;
  int bad   = 0;

  ring_packet_eject #(.HOME_CELL_ID(HOME), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .pkt_fwd(pkt_fwd), .pkt_fwd_valid(pkt_fwd_valid), .pkt_fwd_ready(pkt_fwd_ready),
    .wb_out(wb_out), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .eject_cnt(eject_cnt), .fwd_cnt(fwd_cnt), .dest_err(dest_err)
  );

  always #5 clk = ~clk;

  function automatic packet_t mk(input int dest, input int n);
    packet_t p;
    p.dest_id          = DEST_W'(dest);
    p.payload.atom_idx = 8'(n);
    p.payload.fx       = 16'(n * 3 + 1);
    p.payload.fy       = 16'(n) ^ 16'hA5A5;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input packet_t p);
    pkt_in       = p;
    pkt_in_valid = 1'b1;
  endtask

  initial begin
    packet_t p;
    rst_n         = 1'b0;
    pkt_in        = '0;
    pkt_in_valid  = 1'b0;
    pkt_fwd_ready = 1'b1;
    wb_ready      = 1'b1;
    #12;

    // Reset values
    check("rst_in_ready",  64'(pkt_in_ready),  64'd1);
    check("rst_fwd_valid", 64'(pkt_fwd_valid), 64'd0);
    check("rst_fwd",       64'(pkt_fwd),       64'd0);
    check("rst_wb_valid",  64'(wb_valid),      64'd0);
    check("rst_wb_out",    64'(wb_out),        64'd0);
    check("rst_eject_cnt", 64'(eject_cnt),     64'd0);
    check("rst_fwd_cnt",   64'(fwd_cnt),       64'd0);
    check("rst_dest_err",  64'(dest_err),      64'd0);
    rst_n = 1'b1;
    step();

    // 4 back-to-back ejects with wb_ready high: each payload visible one edge after accept
    for (int i = 0; i < 4; i++) begin
      send(mk(HOME, i));
      step();
      p = mk(HOME, i);
      check("ej_wb_valid", 64'(wb_valid), 64'd1);
      check("ej_wb_out",   64'(wb_out),   64'(p.payload));
    end
    pkt_in_valid = 1'b0;
    step();
    check("ej_drained",   64'(wb_valid),      64'd0);
    check("ej_eject_cnt", 64'(eject_cnt),     64'd4);
    check("ej_fwd_cnt",   64'(fwd_cnt),       64'd0);
    check("ej_no_fwd",    64'(pkt_fwd_valid), 64'd0);

    // 10 forwards to dest 3: pkt_fwd equals input one cycle later
    for (int i = 0; i < 10; i++) begin
      send(mk(3, 10 + i));
      step();
      check("fw_pkt",   64'(pkt_fwd),       64'(mk(3, 10 + i)));
      check("fw_valid", 64'(pkt_fwd_valid), 64'd1);
      check("fw_no_wb", 64'(wb_valid),      64'd0);
    end
    pkt_in_valid = 1'b0;
    step();
    check("fw_drained", 64'(pkt_fwd_valid), 64'd0);
    check("fw_cnt",     64'(fwd_cnt),       64'd10);
    check("fw_ej_cnt",  64'(eject_cnt),     64'd4);

    // Fill FIFO with wb_ready low, then one pop, then wrap-around drain
    wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("full_rdy_before", 64'(pkt_in_ready), 64'd1);
      send(mk(HOME, 20 + i));
      step();
    end
    check("full_rdy_low", 64'(pkt_in_ready), 64'd0);
    send(mk(HOME, 28));
    step();
    p = mk(HOME, 20);
    check("full_held_head", 64'(wb_out),    64'(p.payload));
    check("full_ej_cnt",    64'(eject_cnt), 64'd12);
    wb_ready = 1'b1;
    check("full_rdy_pop_cycle", 64'(pkt_in_ready), 64'd0);
    step();
    wb_ready = 1'b0;
    check("full_rdy_after_pop", 64'(pkt_in_ready), 64'd1);
    step();
    check("full_rdy_refull", 64'(pkt_in_ready), 64'd0);
    check("full_ej_cnt9",    64'(eject_cnt),    64'd13);
    pkt_in_valid = 1'b0;
    wb_ready     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      p = mk(HOME, 21 + k);
      check("wrap_valid", 64'(wb_valid), 64'd1);
      check("wrap_order", 64'(wb_out),   64'(p.payload));
      step();
    end
    check("wrap_empty", 64'(wb_valid), 64'd0);
    send(mk(HOME, 29));
    step();
    pkt_in_valid = 1'b0;
    p = mk(HOME, 29);
    check("tenth_out", 64'(wb_out), 64'(p.payload));
    step();
    check("tenth_popped", 64'(wb_valid),  64'd0);
    check("tenth_ej_cnt", 64'(eject_cnt), 64'd14);

    // Downstream stall: held packet stable, input blocked; release gives no bubble
    pkt_fwd_ready = 1'b0;
    send(mk(3, 40));
    step();
    check("stall_load", 64'(pkt_fwd), 64'(mk(3, 40)));
    send(mk(3, 41));
    check("stall_rdy_low", 64'(pkt_in_ready), 64'd0);
    step();
    step();
    check("stall_pkt_stable", 64'(pkt_fwd),       64'(mk(3, 40)));
    check("stall_valid",      64'(pkt_fwd_valid), 64'd1);
    check("stall_rdy_still",  64'(pkt_in_ready),  64'd0);
    check("stall_fwd_cnt",    64'(fwd_cnt),       64'd11);
    pkt_fwd_ready = 1'b1;
    #1;
    check("stall_rdy_release", 64'(pkt_in_ready), 64'd1);
    step();
    check("stall_next_pkt", 64'(pkt_fwd),       64'(mk(3, 41)));
    check("stall_no_bubble", 64'(pkt_fwd_valid), 64'd1);
    check("stall_fwd_cnt2",  64'(fwd_cnt),       64'd12);
    pkt_in_valid = 1'b0;
    step();
    check("stall_drained", 64'(pkt_fwd_valid), 64'd0);

    // Out-of-range destination: dropped, sticky dest_err, counters unchanged
    send(mk(NUM_CELLS, 50));
    step();
    pkt_in_valid = 1'b0;
    check("bad_err",       64'(dest_err),      64'd1);
    check("bad_ej_cnt",    64'(eject_cnt),     64'd14);
    check("bad_fwd_cnt",   64'(fwd_cnt),       64'd12);
    check("bad_no_fwd",    64'(pkt_fwd_valid), 64'd0);
    check("bad_no_wb",     64'(wb_valid),      64'd0);
    step();
    step();
    check("bad_err_sticky", 64'(dest_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("bad_err_cleared", 64'(dest_err),  64'd0);
    check("bad_cnt_cleared", 64'(eject_cnt), 64'd0);
    #3;
    rst_n = 1'b1;
    step();

    // Forward counter saturates at 2^CW-1 = 15
    for (int i = 0; i < 20; i++) begin
      send(mk(0, 60 + i));
      step();
    end
    pkt_in_valid = 1'b0;
    step();
    check("sat_fwd_cnt", 64'(fwd_cnt),   64'd15);
    check("sat_ej_cnt",  64'(eject_cnt), 64'd0);

    // Reset mid-operation with 3 FIFO entries and a held forward packet
    wb_ready      = 1'b0;
    pkt_fwd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(mk(HOME, 70 + i));
      step();
    end
    send(mk(3, 73));
    step();
    pkt_in_valid = 1'b0;
    check("mid_wb_valid",  64'(wb_valid),      64'd1);
    check("mid_fwd_valid", 64'(pkt_fwd_valid), 64'd1);
    check("mid_ej_cnt",    64'(eject_cnt),     64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  64'(pkt_in_ready),  64'd1);
    check("mid_rst_fwd_valid", 64'(pkt_fwd_valid), 64'd0);
    check("mid_rst_fwd",       64'(pkt_fwd),       64'd0);
    check("mid_rst_wb_valid",  64'(wb_valid),      64'd0);
    check("mid_rst_wb_out",    64'(wb_out),        64'd0);
    check("mid_rst_ej_cnt",    64'(eject_cnt),     64'd0);
    check("mid_rst_fwd_cnt",   64'(fwd_cnt),       64'd0);
    check("mid_rst_dest_err",  64'(dest_err),      64'd0);
    #2;
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    step();
    step();
    check("post_rst_wb_valid",  64'(wb_valid),      64'd0);
    check("post_rst_wb_out",    64'(wb_out),        64'd0);
    check("post_rst_fwd_valid", 64'(pkt_fwd_valid), 64'd0);
    check("post_rst_in_ready",  64'(pkt_in_ready),  64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_packet_eject.md
# ring_packet_eject

Per-node receive end of the force-writeback ring: takes packets arriving from the upstream ring link, ejects those whose destination ID equals this node's cell ID into a local FIFO, and presents them as force writeback requests to the home cell's force cache. All other packets are forwarded downstream through a one-entry output register. One instance sits at each ring node, opposite the cell-to-destination-ID mapping stage that builds the packets.

## Interface
- HOME_CELL_ID, 0: node/cell ID of this instance, range 0..NUM_CELLS-1 (NUM_CELLS from md_pkg)
- FIFO_DEPTH, 8: eject FIFO entries, power of two, >= 2
- CNT_WIDTH, 16: width of the saturating statistics counters

- clk  input  1: sole clock, rising edge
- rst_n  input  1: asynchronous active-low reset
- pkt_in  input  packet_t: packet from upstream ring link (dest_id field + force_wb_t-compatible payload)
- pkt_in_valid  input  1: pkt_in is valid
- pkt_in_ready  output  1: this node accepts pkt_in this cycle
- pkt_fwd  output  packet_t: packet to downstream ring link
- pkt_fwd_valid  output  1: pkt_fwd is valid
- pkt_fwd_ready  input  1: downstream accepts pkt_fwd
- wb_out  output  force_wb_t: writeback request to local force cache (packet payload)
- wb_valid  output  1: wb_out is valid
- wb_ready  input  1: force cache accepts wb_out
- eject_cnt  output  CNT_WIDTH: packets ejected since reset, saturating
- fwd_cnt  output  CNT_WIDTH: packets forwarded since reset, saturating
- dest_err  output  1: sticky; a packet with dest_id >= NUM_CELLS was received

## Operation
- Handshakes are valid/ready; transfer occurs on a rising edge with valid && ready high. Valid must not depend on ready.
- pkt_in_ready = !fifo_full && (!pkt_fwd_valid || pkt_fwd_ready). Independent of pkt_in content, so no valid->ready combinational path.
- Accepted packet classification (on the accepting edge):
  - dest_id == HOME_CELL_ID: payload pushed into eject FIFO; eject_cnt += 1.
  - dest_id >= NUM_CELLS: dropped; dest_err set (sticky until reset); neither counter changes.
  - otherwise: loaded into forward register unchanged (dest_id preserved); fwd_cnt += 1.
- Forward register: pkt_fwd_valid set on load, cleared when drained with no new load in the same cycle; drain and load in the same cycle keeps valid high with the new packet.
- Eject FIFO: first-word-fall-through; wb_out = head entry, wb_valid = !fifo_empty. Pop on wb_valid && wb_ready.
- fifo_full = (count == FIFO_DEPTH). Pointers log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop: count unchanged, both pointers advance; legal at any count from 1 to FIFO_DEPTH-1 (push is blocked when full).
- Counters saturate at 2^CNT_WIDTH-1 and hold.
- Reset mid-operation: FIFO contents, forward register, counters and dest_err discarded immediately; in-flight packets are lost.

## Timing
- Reset values: pkt_in_ready 1, pkt_fwd_valid 0, pkt_fwd 0, wb_valid 0, wb_out 0, eject_cnt 0, fwd_cnt 0, dest_err 0.
- Forward latency: packet accepted at edge N appears on pkt_fwd/pkt_fwd_valid after edge N; sustained throughput 1 packet/cycle while pkt_fwd_ready stays high.
- Eject latency: payload accepted at edge N has wb_valid high after edge N when FIFO was empty; 1 packet/cycle throughput with wb_ready high.
- Full FIFO: pkt_in_ready low from the edge that makes count == FIFO_DEPTH; a pop at edge M raises pkt_in_ready after edge M (not in the same cycle as the pop).
- Ring stall: pkt_in_ready low whenever pkt_fwd_valid && !pkt_fwd_ready, even for a packet destined for this node (head-of-line blocking is intended).
- Counters and dest_err update after the accepting edge.

## Test plan
- Reset then HOME_CELL_ID=5, 4 back-to-back packets dest 5, wb_ready=1 -> wb_valid from cycle after first accept, 4 payloads out in order, eject_cnt=4, fwd_cnt=0.
- 10 packets dest 3, pkt_fwd_ready=1 -> pkt_fwd identical to inputs delayed 1 cycle, fwd_cnt=10, wb_valid stays 0.
- FIFO_DEPTH=8, wb_ready=0, 10 packets dest HOME -> pkt_in_ready low after 8th accept; raise wb_ready for 1 cycle -> ready high next cycle, 9th accepted; order preserved across pointer wrap.
- pkt_fwd_ready=0 with forwarded packet held -> pkt_in_ready=0, pkt_fwd stable; release -> drain and new load same cycle, no bubble.
- Packet with dest_id=NUM_CELLS -> dropped, dest_err=1 and stays 1, counters unchanged; rst_n pulse clears it.
- Assert rst_n low with 3 entries in FIFO and forward register full -> all outputs at reset values immediately, no stale packet after release.
